// File: rtl/mtip_tx_pacer.sv
// Store-and-forward transmit pacer: buffers complete frames from the frame generator and
// forwards them to the MTIP TX FIFO under its ready handshake with a minimum inter-packet gap.
module mtip_tx_pacer #(
  parameter int DEPTH_LOG2   = 10,
  parameter int IPG_CNT      = 2,
  parameter int AFULL_MARGIN = 4
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic [31:0] iDATA,
  input  logic        iDVAL,
  input  logic        iSOP,
  input  logic        iEOP,
  input  logic        iERR,
  output logic        oFIFO_FULL,
  input  logic        iMTIP_TX_RDY,
  output logic [31:0] oMTIP_TX_DATA,
  output logic        oMTIP_TX_WREN,
  output logic        oMTIP_TX_SOP,
  output logic        oMTIP_TX_EOP,
  output logic        oMTIP_TX_ERR,
  output logic        oOVFL,
  output logic        oSYNC_ERR,
  output logic [15:0] oTX_FRAME_CNT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_MARGIN);

  typedef enum logic [2:0] {
    IDLE_ST = 3'b001,
    SEND_ST = 3'b010,
    IPG_ST  = 3'b100
  } state_t;

  // Entry layout: {ERR, EOP, SOP, DATA}
  logic [34:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [CW-1:0]         used_q, used_d, frm_q, frm_d;
  state_t                state_q, state_d;
  logic [3:0]            ipg_q, ipg_d;
  logic [31:0]           data_q, data_d;
  logic                  wren_q, wren_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
  logic                  full_q, full_d, ovfl_q, ovfl_d, sync_q, sync_d;
  logic [15:0]           txcnt_q, txcnt_d;
  logic                  wr_en, rd_en, head_vld;
  logic [34:0]           head, next_head;

  assign rd_nxt    = rd_ptr_q + DEPTH_LOG2'(1);
  assign head_vld  = (used_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign next_head = mem_q[rd_nxt];

  always_ff @(posedge iCLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= {iERR & iEOP, iEOP, iSOP, iDATA};
  end

  always_comb begin
    state_d = state_q;
    ipg_d   = ipg_q;
    data_d  = data_q;
    wren_d  = wren_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    err_d   = err_q;
    txcnt_d = txcnt_q;
    sync_d  = 1'b0;
    rd_en   = 1'b0;
    wr_en   = iDVAL && (used_q != FULL_LVL);
    ovfl_d  = ovfl_q || (iDVAL && (used_q == FULL_LVL));
    case (state_q)
      IDLE_ST: begin
        if (head_vld && !head[32]) begin
          rd_en  = 1'b1;
          sync_d = 1'b1;
        end else if (head_vld && (frm_q != '0)) begin
          state_d = SEND_ST;
          wren_d  = 1'b1;
          {err_d, eop_d, sop_d, data_d} = head;
        end
      end
      SEND_ST: begin
        if (wren_q && iMTIP_TX_RDY) begin
          rd_en = 1'b1;
          if (eop_q) begin
            state_d = IPG_ST;
            ipg_d   = 4'(IPG_CNT);
            txcnt_d = txcnt_q + 16'd1;
            wren_d  = 1'b0;
            {err_d, eop_d, sop_d, data_d} = '0;
          end else begin
            // The rest of the frame is already buffered, so the following entry is valid.
            {err_d, eop_d, sop_d, data_d} = next_head;
          end
        end
      end
      IPG_ST: begin
        if (ipg_q <= 4'd1) state_d = IDLE_ST;
        else               ipg_d   = ipg_q - 4'd1;
      end
      default: state_d = IDLE_ST;
    endcase
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(wr_en);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(rd_en);
    used_d   = used_q + CW'(wr_en) - CW'(rd_en);
    frm_d    = frm_q + CW'(wr_en && iEOP) - CW'(rd_en && head[33]);
    full_d   = (used_q >= AFULL_LVL);
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q  <= IDLE_ST;
      ipg_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      frm_q    <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      err_q    <= 1'b0;
      full_q   <= 1'b0;
      ovfl_q   <= 1'b0;
      sync_q   <= 1'b0;
      txcnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      ipg_q    <= ipg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
      frm_q    <= frm_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      err_q    <= err_d;
      full_q   <= full_d;
      ovfl_q   <= ovfl_d;
      sync_q   <= sync_d;
      txcnt_q  <= txcnt_d;
    end
  end

  assign oFIFO_FULL    = full_q;
  assign oMTIP_TX_DATA = data_q;
  assign oMTIP_TX_WREN = wren_q;
  assign oMTIP_TX_SOP  = sop_q;
  assign oMTIP_TX_EOP  = eop_q;
  assign oMTIP_TX_ERR  = err_q;
  assign oOVFL         = ovfl_q;
  assign oSYNC_ERR     = sync_q;
  assign oTX_FRAME_CNT = txcnt_q;

endmodule

// File: tb/tb_mtip_tx_pacer.sv
// Bench for mtip_tx_pacer: directed frame scenarios plus randomized frames and ready
// toggling, compared against a frame-level scoreboard.
module tb_mtip_tx_pacer;
  localparam int DL2 = 4;
  localparam int IPG = 2;
  localparam int AFM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] idata = '0;
  logic        idval = 1'b0, isop = 1'b0, ieop = 1'b0, ierr = 1'b0;
  logic        rdy = 1'b0;
  logic        full, owren, osop, oeop, oerr, ovfl, syncerr;
  logic [31:0] odata;
  logic [15:0] txcnt;

  mtip_tx_pacer #(.DEPTH_LOG2(DL2), .IPG_CNT(IPG), .AFULL_MARGIN(AFM)) dut (
    .iCLK(clk), .iRESET(rst), .iDATA(idata), .iDVAL(idval), .iSOP(isop), .iEOP(ieop),
    .iERR(ierr), .oFIFO_FULL(full), .iMTIP_TX_RDY(rdy), .oMTIP_TX_DATA(odata),
    .oMTIP_TX_WREN(owren), .oMTIP_TX_SOP(osop), .oMTIP_TX_EOP(oeop), .oMTIP_TX_ERR(oerr),
    .oOVFL(ovfl), .oSYNC_ERR(syncerr), .oTX_FRAME_CNT(txcnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [31:0] d; logic s; logic e; logic r; } xfer_t;
  typedef struct { logic [31:0] d; logic s; logic e; logic r; } word_t;

  xfer_t       xq[$];
  int          sync_cnt = 0, stall_viol = 0, idle_dirty = 0;
  logic        prev_stall = 1'b0;
  logic [35:0] prev_out = '0;
  int          checks = 0, errors = 0;

  // Transfer log and handshake-rule observations, sampled mid-cycle.
  always @(negedge clk) begin
    if (owren === 1'b1 && rdy === 1'b1) xq.push_back('{cyc, odata, osop, oeop, oerr});
    if (syncerr === 1'b1) sync_cnt <= sync_cnt + 1;
    if (prev_stall && ({owren, oerr, oeop, osop, odata} !== prev_out)) stall_viol <= stall_viol + 1;
    if (owren === 1'b0 && ({oerr, oeop, osop, odata} !== 35'd0)) idle_dirty <= idle_dirty + 1;
    prev_stall <= (owren === 1'b1) && (rdy === 1'b0) && !rst;
    prev_out   <= {owren, oerr, oeop, osop, odata};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d, input logic s, input logic e, input logic r);
    idata = d; isop = s; ieop = e; ierr = r; idval = 1'b1;
    tick();
    idata = '0; isop = 1'b0; ieop = 1'b0; ierr = 1'b0; idval = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; idval = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_n(input int n, input int budget);
    int k = 0;
    while (xq.size() < n && k < budget) begin tick(); k++; end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (owren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", owren); end
    checks++; if (odata !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", odata); end
    checks++; if ({osop, oeop, oerr} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {osop, oeop, oerr}); end
    checks++; if ({full, ovfl, syncerr} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {full, ovfl, syncerr}); end
    checks++; if (txcnt !== 16'd0) begin errors++; $display("FAIL reset_txcnt: got %0d want 0", txcnt); end
  endtask

  task automatic test_single_frame();
    word_t f[4];
    int b, w;
    reset_dut(); rdy = 1'b1;
    b = xq.size(); w = 0;
    for (int i = 0; i < 4; i++) begin f[i].d = $urandom; f[i].s = (i == 0); f[i].e = (i == 3); f[i].r = 1'b0; end
    for (int i = 0; i < 4; i++) begin w = cyc; wr(f[i].d, f[i].s, f[i].e, 1'b0); end
    wait_n(b + 4, 40);
    tick(); tick();
    checks++; if (xq.size() - b !== 4) begin errors++; $display("FAIL single_count: got %0d want 4", xq.size() - b); end
    for (int i = 0; i < 4 && b + i < xq.size(); i++) begin
      checks++; if (xq[b+i].c !== w + 2 + i) begin errors++; $display("FAIL single_cycle%0d: got %0d want %0d", i, xq[b+i].c, w + 2 + i); end
      checks++; if ({xq[b+i].d, xq[b+i].s, xq[b+i].e} !== {f[i].d, f[i].s, f[i].e}) begin
        errors++; $display("FAIL single_word%0d: got %h/%b%b want %h/%b%b", i, xq[b+i].d, xq[b+i].s, xq[b+i].e, f[i].d, f[i].s, f[i].e);
      end
    end
    checks++; if (txcnt !== 16'd1) begin errors++; $display("FAIL single_txcnt: got %0d want 1", txcnt); end
  endtask

  task automatic test_back_to_back();
    word_t f[6];
    int b;
    reset_dut(); rdy = 1'b1;
    b = xq.size();
    for (int i = 0; i < 6; i++) begin f[i].d = $urandom; f[i].s = (i % 3 == 0); f[i].e = (i % 3 == 2); f[i].r = 1'b0; end
    for (int i = 0; i < 6; i++) wr(f[i].d, f[i].s, f[i].e, 1'b0);
    wait_n(b + 6, 60);
    tick(); tick();
    checks++; if (xq.size() - b !== 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", xq.size() - b); end
    for (int i = 0; i < 6 && b + i < xq.size(); i++) begin
      checks++; if ({xq[b+i].d, xq[b+i].s, xq[b+i].e} !== {f[i].d, f[i].s, f[i].e}) begin
        errors++; $display("FAIL b2b_word%0d: got %h/%b%b want %h/%b%b", i, xq[b+i].d, xq[b+i].s, xq[b+i].e, f[i].d, f[i].s, f[i].e);
      end
    end
    if (xq.size() >= b + 6) begin
      checks++; if (xq[b+3].c - xq[b+2].c - 1 !== IPG + 1) begin
        errors++; $display("FAIL b2b_gap: got %0d idle cycles want %0d", xq[b+3].c - xq[b+2].c - 1, IPG + 1);
      end
    end
    checks++; if (txcnt !== 16'd2) begin errors++; $display("FAIL b2b_txcnt: got %0d want 2", txcnt); end
  endtask

  task automatic test_stall();
    word_t f[5];
    int b, sv, k;
    reset_dut(); rdy = 1'b0;
    b = xq.size(); sv = stall_viol; k = 0;
    for (int i = 0; i < 5; i++) begin f[i].d = $urandom; f[i].s = (i == 0); f[i].e = (i == 4); f[i].r = 1'b0; end
    for (int i = 0; i < 5; i++) wr(f[i].d, f[i].s, f[i].e, 1'b0);
    while (owren !== 1'b1 && k < 20) begin tick(); k++; end
    checks++; if (owren !== 1'b1) begin errors++; $display("FAIL stall_start: wren %b want 1", owren); end
    rdy = 1'b1; tick();
    rdy = 1'b0; tick(); tick();
    rdy = 1'b1;
    wait_n(b + 5, 30);
    tick(); tick();
    checks++; if (xq.size() - b !== 5) begin errors++; $display("FAIL stall_count: got %0d want 5", xq.size() - b); end
    for (int i = 0; i < 5 && b + i < xq.size(); i++) begin
      checks++; if ({xq[b+i].d, xq[b+i].s, xq[b+i].e} !== {f[i].d, f[i].s, f[i].e}) begin
        errors++; $display("FAIL stall_word%0d: got %h/%b%b want %h/%b%b", i, xq[b+i].d, xq[b+i].s, xq[b+i].e, f[i].d, f[i].s, f[i].e);
      end
    end
    if (xq.size() >= b + 2) begin
      checks++; if (xq[b+1].c - xq[b].c !== 3) begin errors++; $display("FAIL stall_spacing: got %0d want 3", xq[b+1].c - xq[b].c); end
    end
    checks++; if (stall_viol !== sv) begin errors++; $display("FAIL stall_hold: got %0d changes want 0", stall_viol - sv); end
  endtask

  task automatic test_err();
    word_t f[10];
    int b;
    reset_dut(); rdy = 1'b1;
    b = xq.size();
    for (int i = 0; i < 10; i++) begin
      f[i].d = $urandom; f[i].s = (i == 0 || i == 8); f[i].e = (i == 7 || i == 9); f[i].r = (i == 7);
    end
    for (int i = 0; i < 10; i++) wr(f[i].d, f[i].s, f[i].e, f[i].r);
    wait_n(b + 10, 80);
    tick(); tick();
    checks++; if (xq.size() - b !== 10) begin errors++; $display("FAIL err_count: got %0d want 10", xq.size() - b); end
    for (int i = 0; i < 10 && b + i < xq.size(); i++) begin
      checks++; if ({xq[b+i].d, xq[b+i].e, xq[b+i].r} !== {f[i].d, f[i].e, f[i].r}) begin
        errors++; $display("FAIL err_word%0d: got %h e%b r%b want %h e%b r%b", i, xq[b+i].d, xq[b+i].e, xq[b+i].r, f[i].d, f[i].e, f[i].r);
      end
    end
    checks++; if (txcnt !== 16'd2) begin errors++; $display("FAIL err_txcnt: got %0d want 2", txcnt); end
  endtask

  task automatic test_orphan();
    logic [31:0] d0, d1;
    int b, s0, id0;
    reset_dut(); rdy = 1'b1;
    b = xq.size(); s0 = sync_cnt; id0 = idle_dirty;
    d0 = $urandom; d1 = $urandom;
    wr($urandom, 1'b0, 1'b0, 1'b0);
    wr($urandom, 1'b0, 1'b1, 1'b0);
    wr(d0, 1'b1, 1'b0, 1'b0);
    wr(d1, 1'b0, 1'b1, 1'b0);
    wait_n(b + 2, 40);
    tick(); tick(); tick();
    checks++; if (sync_cnt - s0 !== 2) begin errors++; $display("FAIL orphan_sync: got %0d pulses want 2", sync_cnt - s0); end
    checks++; if (xq.size() - b !== 2) begin errors++; $display("FAIL orphan_count: got %0d want 2", xq.size() - b); end
    if (xq.size() >= b + 2) begin
      checks++; if ({xq[b].d, xq[b].s, xq[b].e, xq[b+1].d, xq[b+1].s, xq[b+1].e} !== {d0, 2'b10, d1, 2'b01}) begin
        errors++; $display("FAIL orphan_frame: got %h %h want %h %h", xq[b].d, xq[b+1].d, d0, d1);
      end
    end
    checks++; if (txcnt !== 16'd1) begin errors++; $display("FAIL orphan_txcnt: got %0d want 1", txcnt); end
    checks++; if (idle_dirty !== id0) begin errors++; $display("FAIL orphan_idle_outputs: got %0d dirty cycles want 0", idle_dirty - id0); end
  endtask

  task automatic test_fill();
    logic [31:0] dn;
    int b;
    reset_dut(); rdy = 1'b0;
    b = xq.size();
    for (int i = 1; i <= 17; i++) begin
      wr($urandom, (i == 1), 1'b0, 1'b0);
      tick(); tick();
      if (i == 11) begin checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full11: got %b want 0", full); end end
      if (i == 12) begin checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full12: got %b want 1", full); end end
      if (i == 16) begin checks++; if (ovfl !== 1'b0) begin errors++; $display("FAIL fill_ovfl16: got %b want 0", ovfl); end end
      if (i == 17) begin checks++; if (ovfl !== 1'b1) begin errors++; $display("FAIL fill_ovfl17: got %b want 1", ovfl); end end
    end
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (ovfl !== 1'b1) begin errors++; $display("FAIL fill_ovfl_sticky: got %b want 1", ovfl); end
    checks++; if (xq.size() - b !== 0) begin errors++; $display("FAIL fill_no_send: got %0d transfers want 0", xq.size() - b); end
    rst = 1'b1; tick();
    checks++; if ({owren, ovfl, full, syncerr, odata, txcnt} !== 52'd0) begin
      errors++; $display("FAIL fill_reset_outputs: wren %b ovfl %b full %b sync %b data %h cnt %0d want all 0", owren, ovfl, full, syncerr, odata, txcnt);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    dn = $urandom;
    wr(dn, 1'b1, 1'b1, 1'b0);
    wait_n(b + 1, 20);
    for (int i = 0; i < 6; i++) tick();
    checks++; if (xq.size() - b !== 1) begin errors++; $display("FAIL fill_after_reset_count: got %0d want 1", xq.size() - b); end
    if (xq.size() >= b + 1) begin
      checks++; if (xq[b].d !== dn) begin errors++; $display("FAIL fill_after_reset_data: got %h want %h", xq[b].d, dn); end
    end
  endtask

  task automatic test_random();
    word_t exp_q[$];
    word_t w;
    int    b, nfr, total, sv, id0;
    bit    wdone;
    reset_dut();
    b = xq.size(); nfr = 12; sv = stall_viol; id0 = idle_dirty; wdone = 1'b0;
    for (int f = 0; f < nfr; f++) begin
      int len = $urandom_range(1, 8);
      logic r = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++) begin
        w.d = $urandom; w.s = (i == 0); w.e = (i == len - 1); w.r = w.e && r;
        exp_q.push_back(w);
      end
    end
    total = exp_q.size();
    fork
      begin
        for (int i = 0; i < total; i++) begin
          int wt = 0;
          while (full === 1'b1 && wt < 300) begin tick(); wt++; end
          wr(exp_q[i].d, exp_q[i].s, exp_q[i].e, exp_q[i].r);
          if (exp_q[i].e) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
          end
        end
        wdone = 1'b1;
      end
      begin
        int k = 0;
        while (!(wdone && xq.size() >= b + total) && k < 4000) begin
          rdy = ($urandom_range(0, 3) != 0);
          tick(); k++;
        end
        rdy = 1'b1;
      end
    join
    tick(); tick();
    checks++; if (xq.size() - b !== total) begin errors++; $display("FAIL rand_count: got %0d want %0d", xq.size() - b, total); end
    for (int i = 0; i < total && b + i < xq.size(); i++) begin
      checks++; if ({xq[b+i].d, xq[b+i].s, xq[b+i].e, xq[b+i].r} !== {exp_q[i].d, exp_q[i].s, exp_q[i].e, exp_q[i].r}) begin
        errors++; $display("FAIL rand_word%0d: got %h/%b%b%b want %h/%b%b%b", i, xq[b+i].d, xq[b+i].s, xq[b+i].e, xq[b+i].r,
                           exp_q[i].d, exp_q[i].s, exp_q[i].e, exp_q[i].r);
      end
    end
    for (int i = b + 1; i < xq.size(); i++) begin
      if (xq[i].s && xq[i-1].e) begin
        checks++; if (xq[i].c - xq[i-1].c < IPG + 2) begin
          errors++; $display("FAIL rand_gap: got %0d cycles want >= %0d", xq[i].c - xq[i-1].c, IPG + 2);
        end
      end
    end
    checks++; if (txcnt !== 16'(nfr)) begin errors++; $display("FAIL rand_txcnt: got %0d want %0d", txcnt, nfr); end
    checks++; if (stall_viol !== sv) begin errors++; $display("FAIL rand_hold: got %0d changes want 0", stall_viol - sv); end
    checks++; if (idle_dirty !== id0) begin errors++; $display("FAIL rand_idle_outputs: got %0d dirty cycles want 0", idle_dirty - id0); end
    checks++; if (ovfl !== 1'b0) begin errors++; $display("FAIL rand_ovfl: got %b want 0", ovfl); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_err();
    test_orphan();
    test_random();
    test_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
